// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared SoC constants and helpers for the LED PWM peripheral
package soc_pkg;

  localparam logic [31:0] LEDPWM_BASE_ADDR   = 32'h2000_0000;
  localparam logic [31:0] LEDPWM_OUT         = 32'h00;
  localparam logic [31:0] LEDPWM_MODE        = 32'h04;
  localparam logic [31:0] LEDPWM_PRESC       = 32'h08;
  localparam logic [31:0] LEDPWM_STATUS      = 32'h0C;
  localparam logic [31:0] LEDPWM_DUTY0       = 32'h10;
  localparam logic [31:0] LEDPWM_DUTY_STRIDE = 32'h04;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_OUT,
    SEL_MODE,
    SEL_PRESC,
    SEL_STATUS,
    SEL_DUTY
  } ledpwm_sel_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    lane_mask = {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

endpackage

// File: rtl/ledpwm_timebase.sv
// rtl/ledpwm_timebase.sv - shared prescaler and PWM period counter
module ledpwm_timebase #(
  parameter int PRESC_BITS = 16,
  parameter int PWM_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic                  presc_clr,
  output logic [PWM_BITS-1:0]   pwm_cnt,
  output logic                  tick,
  output logic                  wrap
);

  logic [PRESC_BITS-1:0] r_presc_cnt;
  logic [PWM_BITS-1:0]   r_pwm_cnt;

  assign tick    = (r_presc_cnt == presc);
  assign wrap    = tick && (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign pwm_cnt = r_pwm_cnt;

  // A prescaler reload write restarts the prescale phase but never the PWM phase.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
    end else begin
      if (presc_clr || tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_BITS'(1);
      end
      if (tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/led_pwm_periph.sv
// rtl/led_pwm_periph.sv - memory-mapped LED on/off and PWM peripheral; LEDPWM_IRQ_EN adds the sticky period irq
module led_pwm_periph
  import soc_pkg::*;
#(
  parameter int          NUM_LEDS   = 4,
  parameter int          PWM_BITS   = 8,
  parameter int          PRESC_BITS = 16,
  parameter logic [31:0] BASE_ADDR  = LEDPWM_BASE_ADDR
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wr,
  input  logic [3:0]          data_wr_en,
  output logic [31:0]         data_rd,
  output logic [NUM_LEDS-1:0] led,
  output logic                irq
);

  localparam logic [31:0] WIN_BYTES = LEDPWM_DUTY0 + LEDPWM_DUTY_STRIDE * 32'(NUM_LEDS);

  logic [NUM_LEDS-1:0]   r_out;
  logic [NUM_LEDS-1:0]   r_mode;
  logic [PRESC_BITS-1:0] r_presc;
  logic [PWM_BITS-1:0]   r_duty [NUM_LEDS];
  logic [NUM_LEDS-1:0]   r_led;

  logic [31:0]           w_word_addr;
  logic [31:0]           w_off;
  logic [31:0]           w_duty_idx;
  logic [31:0]           w_wmask;
  logic                  w_sel;
  ledpwm_sel_e           w_reg;
  logic                  w_presc_clr;
  logic [PWM_BITS-1:0]   w_pwm_cnt;
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_irq_pend;
  logic                  w_unused;

  assign w_word_addr = data_addr & ~32'h3;
  assign w_off       = w_word_addr - BASE_ADDR;
  assign w_sel       = (w_word_addr >= BASE_ADDR) && (w_off < WIN_BYTES);
  assign w_duty_idx  = (w_off - LEDPWM_DUTY0) / LEDPWM_DUTY_STRIDE;
  assign w_wmask     = lane_mask(data_wr_en);
  assign w_presc_clr = (w_reg == SEL_PRESC) && data_wr_en[0];

  always_comb begin
    w_reg = SEL_NONE;
    if (w_sel) begin
      if (w_off >= LEDPWM_DUTY0) begin
        w_reg = SEL_DUTY;
      end else begin
        case (w_off)
          LEDPWM_OUT:    w_reg = SEL_OUT;
          LEDPWM_MODE:   w_reg = SEL_MODE;
          LEDPWM_PRESC:  w_reg = SEL_PRESC;
          LEDPWM_STATUS: w_reg = SEL_STATUS;
          default:       w_reg = SEL_NONE;
        endcase
      end
    end
  end

  ledpwm_timebase #(
    .PRESC_BITS(PRESC_BITS),
    .PWM_BITS  (PWM_BITS)
  ) u_timebase (
    .clk      (clk),
    .resetn   (resetn),
    .presc    (r_presc),
    .presc_clr(w_presc_clr),
    .pwm_cnt  (w_pwm_cnt),
    .tick     (w_tick),
    .wrap     (w_wrap)
  );

  // Byte-lane merge: bits beyond each register's width are simply dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out   <= '0;
      r_mode  <= '0;
      r_presc <= '0;
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
    end else begin
      if (w_reg == SEL_OUT)
        r_out <= (r_out & ~w_wmask[NUM_LEDS-1:0]) | (data_wr[NUM_LEDS-1:0] & w_wmask[NUM_LEDS-1:0]);
      if (w_reg == SEL_MODE)
        r_mode <= (r_mode & ~w_wmask[NUM_LEDS-1:0]) | (data_wr[NUM_LEDS-1:0] & w_wmask[NUM_LEDS-1:0]);
      if (w_reg == SEL_PRESC)
        r_presc <= (r_presc & ~w_wmask[PRESC_BITS-1:0]) | (data_wr[PRESC_BITS-1:0] & w_wmask[PRESC_BITS-1:0]);
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_reg == SEL_DUTY && w_duty_idx == 32'(i))
          r_duty[i] <= (r_duty[i] & ~w_wmask[PWM_BITS-1:0]) | (data_wr[PWM_BITS-1:0] & w_wmask[PWM_BITS-1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        r_led[i] <= r_mode[i] ? (w_pwm_cnt < r_duty[i]) : r_out[i];
    end
  end

  assign led = r_led;

`ifdef LEDPWM_IRQ_EN
  logic r_irq_pend;

  // Set has priority so a wrap coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_irq_pend <= 1'b0;
    end else if (w_wrap) begin
      r_irq_pend <= 1'b1;
    end else if (w_reg == SEL_STATUS && data_wr_en[0] && data_wr[0]) begin
      r_irq_pend <= 1'b0;
    end
  end

  assign w_irq_pend = r_irq_pend;
`else
  assign w_irq_pend = 1'b0;
`endif

  assign irq = w_irq_pend;

  always_comb begin
    data_rd = '0;
    case (w_reg)
      SEL_OUT:    data_rd = 32'(r_out);
      SEL_MODE:   data_rd = 32'(r_mode);
      SEL_PRESC:  data_rd = 32'(r_presc);
      SEL_STATUS: data_rd = {31'b0, w_irq_pend};
      SEL_DUTY: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (w_duty_idx == 32'(i)) data_rd = 32'(r_duty[i]);
        end
      end
      default:    data_rd = '0;
    endcase
  end

  assign w_unused = ^{data_wr, w_wmask, w_tick, w_wrap};

endmodule

// File: tb/tb_led_pwm_periph.sv
// tb/tb_led_pwm_periph.sv - directed table-driven bench for led_pwm_periph
module tb_led_pwm_periph;

  localparam logic [31:0] B = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wr = '0;
  logic [3:0]  data_wr_en = '0;
  logic [31:0] data_rd;
  logic [3:0]  led;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  led_pwm_periph dut (
    .clk       (clk),
    .resetn    (resetn),
    .data_addr (data_addr),
    .data_wr   (data_wr),
    .data_wr_en(data_wr_en),
    .data_rd   (data_rd),
    .led       (led),
    .irq       (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  en;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    data_addr  = a;
    data_wr    = d;
    data_wr_en = en;
    @(posedge clk);
    #1;
    data_wr_en = 4'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    data_wr_en = 4'b0;
    data_addr  = a;
    #1;
    d = data_rd;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) begin
      data_addr  = B + 32'($urandom_range(0, 7)) * 4;
      data_wr    = $urandom;
      data_wr_en = 4'($urandom);
      @(posedge clk);
      #1;
    end
    data_wr_en = 4'b0;
    resetn     = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] rd;
    check({name, "_led"}, 32'(led), 32'h0);
    check({name, "_irq"}, 32'(irq), 32'h0);
    for (int k = 0; k < 8; k++) begin
      bus_read(B + 32'(k) * 4, rd);
      check({name, "_reg"}, rd, 32'h0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        prev;
    logic        found;
    int          highs;
    int          rise_at;
    int          c;

    vecs[0]  = '{"out_full",        B + 32'h00,  32'h0000_0005, 4'b1111, B + 32'h00,  32'h5};
    vecs[1]  = '{"presc_lane0",     B + 32'h08,  32'h0000_AABB, 4'b0001, B + 32'h08,  32'hBB};
    vecs[2]  = '{"presc_lane1",     B + 32'h08,  32'h1234_CC00, 4'b0010, B + 32'h08,  32'hCCBB};
    vecs[3]  = '{"presc_hi_lanes",  B + 32'h08,  32'hFFFF_0000, 4'b1100, B + 32'h08,  32'hCCBB};
    vecs[4]  = '{"outside_window",  B + 32'h100, 32'hFFFF_FFFF, 4'b1111, B + 32'h100, 32'h0};
    vecs[5]  = '{"outside_no_eff",  B + 32'h100, 32'h0,         4'b0000, B + 32'h00,  32'h5};
    vecs[6]  = '{"out_unimpl",      B + 32'h00,  32'h0000_00FF, 4'b1111, B + 32'h00,  32'hF};
    vecs[7]  = '{"out_low_bits",    B + 32'h03,  32'h0000_0005, 4'b0001, B + 32'h01,  32'h5};
    vecs[8]  = '{"mode_partial",    B + 32'h04,  32'h0000_1234, 4'b0011, B + 32'h04,  32'h4};
    vecs[9]  = '{"duty3",           B + 32'h1C,  32'h0000_ABCD, 4'b0011, B + 32'h1C,  32'hCD};
    vecs[10] = '{"duty_past_end",   B + 32'h20,  32'h0000_00FF, 4'b1111, B + 32'h20,  32'h0};
    vecs[11] = '{"below_base",      B - 32'h04,  32'h0000_00FF, 4'b1111, B - 32'h04,  32'h0};
    vecs[12] = '{"status_idle",     B + 32'h0C,  32'h0000_0001, 4'b0001, B + 32'h0C,  32'h0};
    vecs[13] = '{"duty3_hi_lane",   B + 32'h1C,  32'h0011_0011, 4'b0100, B + 32'h1C,  32'hCD};

    do_reset();
    check_all_zero("reset");

    bus_write(B, 32'h5, 4'b1111);
    check("direct_led_k", 32'(led), 32'h0);
    @(posedge clk);
    #1;
    check("direct_led_k1", 32'(led), 32'h5);
    bus_read(B, rd);
    check("direct_read", rd, 32'h5);

    for (int v = 0; v < 14; v++) begin
      bus_write(vecs[v].waddr, vecs[v].wdata, vecs[v].en);
      bus_read(vecs[v].raddr, rd);
      check(vecs[v].name, rd, vecs[v].exp_rd);
    end
    @(posedge clk);
    #1;
    check("table_led", 32'(led), 32'h1);

    bus_write(B + 32'h04, 32'h2, 4'b1111);
    bus_write(B + 32'h14, 32'd128, 4'b1111);
    bus_write(B + 32'h08, 32'h3, 4'b1111);
    prev  = led[1];
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!prev && led[1]) found = 1'b1;
      prev = led[1];
    end
    check("presc3_rise_found", 32'(found), 32'h1);

    highs   = 0;
    rise_at = 0;
    prev    = led[1];
    for (int i = 1; i <= 1024; i++) begin
      @(posedge clk);
      #1;
      highs += int'(led[1]);
      if (!prev && led[1]) rise_at = i;
      prev = led[1];
    end
    check("presc3_high", 32'(highs), 32'd512);
    check("presc3_period", 32'(rise_at), 32'd1024);

    bus_write(B + 32'h08, 32'h3, 4'b0001);
    c     = 1;
    prev  = led[1];
    found = 1'b0;
    while (!found && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
      if (!prev && led[1]) found = 1'b1;
      prev = led[1];
    end
    check("presc_restart_period", 32'(c), 32'd1026);

    do_reset();
    check_all_zero("midreset");

    bus_write(B + 32'h04, 32'h1, 4'b1111);
    bus_write(B + 32'h10, 32'd64, 4'b0001);
    for (int e = 3; e <= 300; e++) begin
      @(posedge clk);
      #1;
      check("phase_led0", 32'(led[0]), 32'((((e - 1) % 256) < 64) ? 1 : 0));
`ifdef LEDPWM_IRQ_EN
      check("phase_irq", 32'(irq), 32'((e >= 256) ? 1 : 0));
`else
      check("phase_irq", 32'(irq), 32'h0);
`endif
    end

`ifdef LEDPWM_IRQ_EN
    bus_read(B + 32'h0C, rd);
    check("status_pend", rd, 32'h1);
    bus_write(B + 32'h0C, 32'h1, 4'b0001);
    check("irq_cleared", 32'(irq), 32'h0);
    repeat (210) @(posedge clk);
    #1;
    bus_write(B + 32'h0C, 32'h1, 4'b0001);
    check("irq_set_wins", 32'(irq), 32'h1);
    bus_write(B + 32'h0C, 32'h1, 4'b0001);
    check("irq_cleared_again", 32'(irq), 32'h0);
`else
    bus_read(B + 32'h0C, rd);
    check("status_absent", rd, 32'h0);
`endif

    bus_write(B + 32'h10, 32'd0, 4'b0001);
    repeat (2) @(posedge clk);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      highs += int'(led[0]);
    end
    check("duty0_never_high", 32'(highs), 32'd0);

    bus_write(B + 32'h10, 32'd255, 4'b0001);
    repeat (2) @(posedge clk);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      highs += int'(led[0]);
    end
    check("duty255_high", 32'(highs), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pwm_periph.md
Name: led_pwm_periph

Overview:
- Memory-mapped LED peripheral on the CPU data bus; successor to the single 4-bit LED register in the SoC top level.
- Parametrised channel count. Each channel can be a direct on/off output or a PWM output.
- A shared prescaler and PWM counter drive all channels. Byte-lane writes are supported.
- An optional sticky period interrupt is available.
- The SoC top level instantiates it at 0x20000000 and muxes its data_rd into the CPU read path.

Parameters:
- NUM_LEDS, 4: channel count, 1..16.
- PWM_BITS, 8: PWM counter and duty width, 1..16.
- PRESC_BITS, 16: prescaler reload width, 1..32.
- BASE_ADDR, 32'h20000000: window base, word aligned.

Ports:
- clk, input, 1: system clock, rising edge.
- resetn, input, 1: synchronous reset, active low.
- data_addr, input, 32: CPU byte address.
- data_wr, input, 32: write data.
- data_wr_en, input, 4: byte-lane write enables (bit n = byte n).
- data_rd, output, 32: combinational read data; 0 outside the window.
- led, output, NUM_LEDS: registered LED outputs.
- irq, output, 1: period interrupt (only with LEDPWM_IRQ_EN; otherwise tied 0).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is resetn: synchronous, active low, sampled on the rising clk edge.
- Decode:
  - Select when data_addr[31:2] falls in the window [BASE_ADDR, BASE_ADDR+0x10+4*NUM_LEDS).
  - data_addr[1:0] is ignored.
  - Offset = word index within the window.
- Register map (offsets from BASE_ADDR):
  - 0x00 OUT [NUM_LEDS-1:0]: direct levels.
  - 0x04 MODE [NUM_LEDS-1:0]: 1 = channel is PWM.
  - 0x08 PRESC [PRESC_BITS-1:0]: prescaler reload.
  - 0x0C STATUS: bit0 = irq_pend (write 1 to clear).
  - 0x10+4i DUTY[i] [PWM_BITS-1:0].
- Register access:
  - Unimplemented bits read 0 and ignore writes.
- Writes:
  - Each byte lane whose data_wr_en bit is set updates the corresponding register bits at the clk edge.
  - Partial writes leave the other lanes unchanged.
  - A write outside the window has no effect.
- Reads:
  - Combinational from data_addr, with no wait states.
- Reset (resetn=0 at an edge):
  - OUT, MODE, PRESC, all DUTY, presc_cnt, pwm_cnt, irq_pend and led are all 0.
  - A reset in the middle of a PWM period aborts it; the counters restart from 0 on the first cycle after release.
- Timebase:
  - presc_cnt counts 0..PRESC.
  - tick = (presc_cnt == PRESC); on tick, presc_cnt returns to 0.
  - PRESC = 0 gives a tick every cycle.
  - On tick, pwm_cnt increments modulo 2^PWM_BITS.
  - Any write touching PRESC lane 0 also clears presc_cnt to 0 in the same edge (pwm_cnt unaffected).
- Output:
  - At each edge, led[i] <= MODE[i] ? (pwm_cnt < DUTY[i]) : OUT[i].
  - Latency: a write issued in cycle k updates the register at the end of k; led reflects it at the end of k+1.
  - DUTY = 0 means the output is constant 0.
  - DUTY = 2^PWM_BITS-1 means the output is high for all but one count per period.
- Simultaneous events:
  - A write to OUT and a MODE change in the same cycle both take effect; led uses the new values on the next edge.

Optional Feature:
- Macro LEDPWM_IRQ_EN.
- Defined:
  - irq_pend is set on the tick where pwm_cnt wraps from max to 0.
  - irq = irq_pend.
  - A STATUS write with data_wr[0]=1 on lane 0 clears irq_pend.
  - If set and clear happen in the same cycle, set wins.
- Undefined:
  - STATUS reads 0 and writes are ignored.
  - irq is constant 0; no irq_pend flop exists.

Decomposition:
- Shared package soc_pkg:
  - Register offset constants (LEDPWM_OUT, _MODE, _PRESC, _STATUS, _DUTY0).
  - DUTY stride constant.
  - Default BASE_ADDR.
- Sub-module ledpwm_timebase (parameters PRESC_BITS, PWM_BITS):
  - Inputs: clk, resetn, presc, presc_clr.
  - Outputs: pwm_cnt, tick, wrap.
- Register file, decode and output compare stay in the top module.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with random bus writes → led=0, every register reads 0, irq=0.
- Direct mode: write 0x20000000 = 0x5, en=4'b1111 → led=4'b0101 two edges after the write cycle; read returns 0x5.
- Byte lanes and decode:
  - Write 0x20000008 = 0xAABB with en=4'b0001 → PRESC reads 0x00BB.
  - Write to 0x20000100 → no register changes; read of 0x20000100 returns 0.
- PWM, PRESC=0: MODE=0x1, DUTY0=64 → led[0] high 64 of every 256 cycles; DUTY0=0 → never high; DUTY0=255 → high 255 of 256.
- PWM, PRESC=3: DUTY1=128, MODE=0x2 → period 1024 cycles, led[1] high for 512; rewriting PRESC mid-period restarts the prescale count.
- With LEDPWM_IRQ_EN, PRESC=0:
  - irq rises one cycle after pwm_cnt wraps 255→0.
  - Write STATUS=1 → irq clears.
  - Clear coinciding with a wrap → irq stays 1.
